cm_bus_tx: RTL and testbench

// - FPGA->Xmega byte transmitter over the 8-bit chip-interconnect bus; the outbound

---
 rtl/cm_bus_pkg.sv | 8 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/cm_bus_tx.sv | 86 ++++++++
 tb/tb_cm_bus_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_bus_pkg.sv
// cm_bus_pkg: bus width, FSM states and default timing shared by the CM transmit and receive paths
package cm_bus_pkg;
  localparam int CM_W           = 8;
  localparam int CM_DEPTH       = 4;
  localparam int CM_SETUP_CYC   = 4;
  localparam int CM_TIMEOUT_CYC = 50000;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RECOVER} cm_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; read data is the current head entry
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_lvl
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_lvl;
  logic          w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_lvl == LW'(DEPTH);
  assign o_empty = r_lvl == '0;
  assign o_lvl   = r_lvl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lvl  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_lvl <= r_lvl + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/cm_bus_tx.sv
// cm_bus_tx: FPGA->Xmega byte transmitter, FIFO-buffered, 4-phase strobe/ack handshake with ack timeout
module cm_bus_tx import cm_bus_pkg::*; #(
  parameter int DEPTH       = CM_DEPTH,
  parameter int SETUP_CYC   = CM_SETUP_CYC,
  parameter int TIMEOUT_CYC = CM_TIMEOUT_CYC
) (
  input  logic                     CLK_50,
  input  logic                     RST_n,
  input  logic [CM_W-1:0]          TX_DATA,
  input  logic                     TX_VALID,
  output logic                     TX_READY,
  output logic [CM_W-1:0]          CM_OUT,
  output logic                     CM_STB,
  input  logic                     CM_ACK,
  output logic                     BUSY,
  output logic                     ERR_TIMEOUT,
  input  logic                     CLR_ERR,
  output logic [$clog2(DEPTH):0]   FIFO_LVL
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  cm_state_t       r_state, w_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_ack_sync;
  logic            r_init, r_err, r_stb;
  logic [CM_W-1:0] r_out, w_head;
  logic            w_ack_s, w_full, w_empty, w_push, w_pop, w_to, w_setup_done, w_set;
  assign w_ack_s      = r_ack_sync[1];
  assign w_push       = TX_VALID && TX_READY;
  assign w_pop        = (r_state == IDLE) && (w_nxt == SETUP);
  assign w_to         = r_cnt == CW'(TIMEOUT_CYC - 1);
  assign w_setup_done = r_cnt == CW'(SETUP_CYC - 1);
  assign TX_READY     = r_init && !w_full;
  assign CM_OUT       = r_out;
  assign CM_STB       = r_stb;
  assign ERR_TIMEOUT  = r_err;
  assign BUSY         = (r_state != IDLE) || !w_empty;
  sync_fifo #(.W(CM_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK_50),
    .rst_n   (RST_n),
    .i_push  (w_push),
    .i_data  (TX_DATA),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_lvl   (FIFO_LVL)
  );
  always_comb begin
    w_nxt = r_state;
    w_set = 1'b0;
    case (r_state)
      IDLE:    w_nxt = (!w_empty && !w_ack_s) ? SETUP : IDLE;
      SETUP:   w_nxt = w_setup_done ? STROBE : SETUP;
      STROBE: begin
        w_nxt = w_ack_s ? RELEASE : w_to ? RECOVER : STROBE;
        w_set = !w_ack_s && w_to;
      end
      RELEASE: begin
        w_nxt = !w_ack_s ? IDLE : w_to ? RECOVER : RELEASE;
        w_set = w_ack_s && w_to;
      end
      RECOVER: w_nxt = w_ack_s ? RECOVER : IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // Strobe is registered from the next state so it toggles glitch-free with the state change.
  always_ff @(posedge CLK_50 or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack_sync <= '0;
      r_init     <= 1'b0;
      r_err      <= 1'b0;
      r_out      <= '0;
      r_stb      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= (w_nxt != r_state) ? '0 : (r_cnt == CW'(TIMEOUT_CYC)) ? r_cnt : r_cnt + 1'b1;
      r_ack_sync <= {r_ack_sync[0], CM_ACK};
      r_init     <= 1'b1;
      r_err      <= w_set || (r_err && !CLR_ERR);
      r_stb      <= w_nxt == STROBE;
      if (w_pop) r_out <= w_head;
    end
  end
endmodule

// File: tb/tb_cm_bus_tx.sv
// tb_cm_bus_tx: directed checks of cm_bus_tx against a behavioural Xmega ack responder
module tb_cm_bus_tx;
  localparam int SU = 4;
  localparam int TO = 40;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ack = 1'b0;
  logic       clr = 1'b0;
  logic       tx_ready, stb, busy, err;
  logic [7:0] cm_out;
  logic [2:0] lvl;
  logic       ack_en = 1'b1;
  logic       ack_force = 1'b0;
  logic [7:0] sent[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #10 clk = ~clk;

  cm_bus_tx #(.DEPTH(4), .SETUP_CYC(SU), .TIMEOUT_CYC(TO)) dut (
    .CLK_50(clk), .RST_n(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .CM_OUT(cm_out), .CM_STB(stb), .CM_ACK(ack), .BUSY(busy), .ERR_TIMEOUT(err),
    .CLR_ERR(clr), .FIFO_LVL(lvl)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic sig(input int s);
    return s == 0 ? stb : s == 1 ? busy : s == 2 ? err : ack;
  endfunction

  task automatic wait_sig(input string tag, input int s, input logic v, output int cyc);
    cyc = 0;
    while (sig(s) !== v && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (cyc >= 2000) chk({tag, "_tmo"}, 32'(sig(s)), 32'(v));
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("push_tmo", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  // Xmega model: ack 3 cycles after strobe seen, release 3 cycles after strobe drops; also logs strobed bytes.
  initial begin
    int   hi = 0;
    int   lo = 0;
    logic prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stb && !prev) sent.push_back(cm_out);
      prev = stb;
      if (ack_force) ack = 1'b1;
      else if (!ack_en) ack = 1'b0;
      else if (stb && !ack) begin
        hi++;
        if (hi == 3) begin ack = 1'b1; hi = 0; end
      end else if (!stb && ack) begin
        lo++;
        if (lo == 3) begin ack = 1'b0; lo = 0; end
      end else begin
        hi = 0;
        lo = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    logic [7:0] exp_log[$] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    #25;
    chk("rst_out", 32'(cm_out), 32'h00);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_lvl", 32'(lvl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(tx_ready), 32'd1);

    // single byte
    push(8'hA5);
    chk("t1_no_bypass", 32'(cm_out), 32'h00);
    chk("t1_busy", 32'(busy), 32'd1);
    c = 0;
    while (cm_out !== 8'hA5 && c < 10) begin tick(); c++; end
    chk("t1_load_lat", 32'(c), 32'd1);
    c = 0;
    while (!stb && c < 20) begin tick(); c++; end
    chk("t1_setup_len", 32'(c), 32'(SU));
    wait_sig("t1_ack", 3, 1'b1, c);
    tick();
    c = 0;
    while (stb && c < 20) begin tick(); c++; end
    chk("t1_stb_fall", 32'(c), 32'd2);
    wait_sig("t1_idle", 1, 1'b0, c);
    chk("t1_out_hold", 32'(cm_out), 32'hA5);

    // fill / back-pressure
    @(negedge clk);
    ack_en = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t2_lvl_full", 32'(lvl), 32'd4);
    chk("t2_ready_low", 32'(tx_ready), 32'd0);
    chk("t2_inflight", 32'(cm_out), 32'h01);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h06;
    repeat (3) tick();
    chk("t2_held_lvl", 32'(lvl), 32'd4);
    chk("t2_stb_high", 32'(stb), 32'd1);
    @(negedge clk);
    ack_en = 1'b1;
    push(8'h06);
    wait_sig("t2_idle", 1, 1'b0, c);
    chk("t2_last", 32'(cm_out), 32'h06);

    // strobe timeout, with CLR_ERR held high across the setting edge
    @(negedge clk);
    ack_en = 1'b0;
    clr    = 1'b1;
    push(8'h11);
    push(8'h22);
    wait_sig("t3_stb", 0, 1'b1, c);
    c = 0;
    while (stb && c < 200) begin tick(); c++; end
    chk("t3_to_len", 32'(c), 32'(TO));
    chk("t3_err_set_wins", 32'(err), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    ack_en = 1'b1;
    wait_sig("t3_next", 0, 1'b1, c);
    chk("t3_next_byte", 32'(cm_out), 32'h22);
    wait_sig("t3_idle", 1, 1'b0, c);
    chk("t3_err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tick();
    chk("t3_clr", 32'(err), 32'd0);

    // stuck ack: release-phase timeout then recovery
    @(negedge clk);
    ack_en = 1'b0;
    push(8'h33);
    push(8'h44);
    wait_sig("t4_stb", 0, 1'b1, c);
    @(negedge clk);
    ack_force = 1'b1;
    wait_sig("t4_stb_fall", 0, 1'b0, c);
    wait_sig("t4_err", 2, 1'b1, c);
    repeat (10) tick();
    chk("t4_stb_low", 32'(stb), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_queued", 32'(lvl), 32'd1);
    chk("t4_out_hold", 32'(cm_out), 32'h33);
    @(negedge clk);
    ack_force = 1'b0;
    ack_en    = 1'b1;
    wait_sig("t4_next", 0, 1'b1, c);
    chk("t4_next_byte", 32'(cm_out), 32'h44);
    wait_sig("t4_idle", 1, 1'b0, c);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // simultaneous push and pop with two entries queued behind a held ack
    @(negedge clk);
    ack_force = 1'b1;
    repeat (3) tick();
    push(8'h55);
    push(8'h66);
    tick();
    chk("t5_idle_hold_lvl", 32'(lvl), 32'd2);
    chk("t5_idle_hold_out", 32'(cm_out), 32'h44);
    @(negedge clk);
    ack_force = 1'b0;
    ack_en    = 1'b0;
    repeat (2) @(negedge clk);
    push(8'h77);
    chk("t5_lvl_same", 32'(lvl), 32'd2);
    chk("t5_popped", 32'(cm_out), 32'h55);
    @(negedge clk);
    ack_en = 1'b1;
    wait_sig("t5_idle", 1, 1'b0, c);

    // reset mid-transfer
    @(negedge clk);
    ack_en = 1'b0;
    push(8'h88);
    push(8'h99);
    push(8'hAA);
    chk("t6_lvl_pre", 32'(lvl), 32'd2);
    wait_sig("t6_stb", 0, 1'b1, c);
    #5 rst_n = 1'b0;
    #1;
    chk("t6_stb", 32'(stb), 32'd0);
    chk("t6_out", 32'(cm_out), 32'h00);
    chk("t6_lvl", 32'(lvl), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_ready", 32'(tx_ready), 32'd1);
    repeat (8) tick();
    chk("t6_quiet", 32'(busy), 32'd0);

    chk("log_len", 32'(sent.size()), 32'(exp_log.size()));
    foreach (exp_log[i]) chk($sformatf("log%0d", i), i < sent.size() ? 32'(sent[i]) : 32'hFFFF, 32'(exp_log[i]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
